// File: rtl/jtag_emu_pkg.sv
// Shared types and constants for the JTAG shift engine.
package jtag_emu_pkg;

    localparam int unsigned JTAG_MAX_BITS = 32;
    localparam int unsigned JTAG_LEN_W    = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } jtag_state_e;

    // Requested lengths beyond the word width shift the whole word.
    function automatic logic [JTAG_LEN_W-1:0] clip_len(input logic [JTAG_LEN_W-1:0] len);
        return (len > JTAG_LEN_W'(JTAG_MAX_BITS)) ? JTAG_LEN_W'(JTAG_MAX_BITS) : len;
    endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// TCK half-period timer: reloads on i_load, counts down while enabled,
// flags the last cycle of a half-period.
module jtag_tck_div #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_phase_done_c
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(HALF_DIV - 1);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_phase_done_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/jtag_shift_engine.sv
// Command-driven JTAG shifter: generates TCK, drives TMS/TDI LSB first,
// captures TDO on each rising TCK and returns the captured word.
module jtag_shift_engine
    import jtag_emu_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned MAX_BITS = JTAG_MAX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [JTAG_LEN_W-1:0] cmd_len_i,
    input  logic [MAX_BITS-1:0]   cmd_tms_i,
    input  logic [MAX_BITS-1:0]   cmd_tdi_i,
    input  logic                  trst_req_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [MAX_BITS-1:0]   rsp_tdo_o,
    output logic                  tck_o,
    output logic                  tms_o,
    output logic                  tdi_o,
    output logic                  trstn_o,
    input  logic                  tdo_i
);

    localparam int unsigned IDX_W = $clog2(MAX_BITS);

    jtag_state_e           r_state;
    logic [MAX_BITS-1:0]   r_tms;
    logic [MAX_BITS-1:0]   r_tdi;
    logic [JTAG_LEN_W-1:0] r_len;
    logic [IDX_W-1:0]      r_idx;
    logic [MAX_BITS-1:0]   r_cap;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic                  r_tck;
    logic                  r_tms_out;
    logic                  r_tdi_out;
    logic                  r_trstn;

    jtag_state_e           w_state_next;
    logic [MAX_BITS-1:0]   w_tms_next;
    logic [MAX_BITS-1:0]   w_tdi_next;
    logic [JTAG_LEN_W-1:0] w_len_next;
    logic [IDX_W-1:0]      w_idx_next;
    logic [MAX_BITS-1:0]   w_cap_next;
    logic                  w_tms_out_next;
    logic                  w_tdi_out_next;
    logic                  w_div_load;
    logic                  w_div_en;
    logic                  w_phase_done;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [JTAG_LEN_W-1:0] w_len_clip;

    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_len_clip = clip_len(cmd_len_i);

    jtag_tck_div #(
        .HALF_DIV(HALF_DIV)
    ) u_div (
        .clk            (clk),
        .rst            (rst),
        .i_load         (w_div_load),
        .i_en           (w_div_en),
        .o_phase_done_c (w_phase_done)
    );

    // Next-state and datapath updates.
    always_comb begin
        w_state_next   = r_state;
        w_tms_next     = r_tms;
        w_tdi_next     = r_tdi;
        w_len_next     = r_len;
        w_idx_next     = r_idx;
        w_cap_next     = r_cap;
        w_tms_out_next = r_tms_out;
        w_tdi_out_next = r_tdi_out;
        w_div_load     = 1'b0;
        w_div_en       = (r_state == LOW) || (r_state == HIGH);

        case (r_state)
            IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_tms_next = cmd_tms_i;
                    w_tdi_next = cmd_tdi_i;
                    w_len_next = w_len_clip;
                    w_idx_next = '0;
                    w_cap_next = '0;
                    w_div_load = 1'b1;
                    if (w_len_clip == '0) begin
                        w_state_next = DONE;
                    end else begin
                        w_tms_out_next = cmd_tms_i[0];
                        w_tdi_out_next = cmd_tdi_i[0];
                        w_state_next   = LOW;
                    end
                end
            end
            LOW: begin
                if (w_phase_done) begin
                    w_cap_next[r_idx] = tdo_i;
                    w_div_load        = 1'b1;
                    w_state_next      = HIGH;
                end
            end
            HIGH: begin
                if (w_phase_done) begin
                    if (JTAG_LEN_W'(r_idx) == (r_len - JTAG_LEN_W'(1))) begin
                        w_state_next = DONE;
                    end else begin
                        w_idx_next     = w_idx_inc;
                        w_tms_out_next = r_tms[w_idx_inc];
                        w_tdi_out_next = r_tdi[w_idx_inc];
                        w_div_load     = 1'b1;
                        w_state_next   = LOW;
                    end
                end
            end
            DONE: begin
                if (r_rsp_valid && rsp_ready_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, datapath and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tms       <= '0;
            r_tdi       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_cap       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_tck       <= 1'b0;
            r_tms_out   <= 1'b1;
            r_tdi_out   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tms       <= w_tms_next;
            r_tdi       <= w_tdi_next;
            r_len       <= w_len_next;
            r_idx       <= w_idx_next;
            r_cap       <= w_cap_next;
            r_cmd_ready <= (w_state_next == IDLE);
            r_rsp_valid <= (w_state_next == DONE);
            r_tck       <= (w_state_next == HIGH);
            r_tms_out   <= w_tms_out_next;
            r_tdi_out   <= w_tdi_out_next;
        end
    end

    // TAP reset follows the request directly, regardless of shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trstn <= 1'b0;
        end else begin
            r_trstn <= ~trst_req_i;
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_tdo_o   = r_cap;
    assign tck_o       = r_tck;
    assign tms_o       = r_tms_out;
    assign tdi_o       = r_tdi_out;
    assign trstn_o     = r_trstn;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed scoreboard bench for jtag_shift_engine with HALF_DIV=2.
module tb_jtag_shift_engine;

    localparam int HD = 2;

    typedef struct {
        logic [31:0] tdo;
        int          lat;
        int          pulses;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [5:0]  cmd_len_i;
    logic [31:0] cmd_tms_i;
    logic [31:0] cmd_tdi_i;
    logic        trst_req_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_tdo_o;
    logic        tck_o;
    logic        tms_o;
    logic        tdi_o;
    logic        trstn_o;
    logic        tdo_i;

    bit   loop_en = 1'b0;
    logic fix_tdo = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign tdo_i = loop_en ? tdi_o : fix_tdo;

    jtag_shift_engine #(
        .HALF_DIV(HD),
        .MAX_BITS(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_len_i   (cmd_len_i),
        .cmd_tms_i   (cmd_tms_i),
        .cmd_tdi_i   (cmd_tdi_i),
        .trst_req_i  (trst_req_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_tdo_o   (rsp_tdo_o),
        .tck_o       (tck_o),
        .tms_o       (tms_o),
        .tdi_o       (tdi_o),
        .trstn_o     (trstn_o),
        .tdo_i       (tdo_i)
    );

    // Pin monitor: TCK rising edges, high-phase width, bit changes while TCK high.
    int   rise_cnt     = 0;
    int   tms_zero_cnt = 0;
    int   chg_hi_cnt   = 0;
    int   width_bad    = 0;
    int   hi_run       = 0;
    logic prev_tck     = 1'b0;
    logic prev_tms     = 1'b1;
    logic prev_tdi     = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            hi_run = 0;
        end else begin
            if (tck_o === 1'b1 && prev_tck !== 1'b1) rise_cnt++;
            if (tck_o === 1'b1) begin
                hi_run++;
            end else begin
                if (hi_run != 0 && hi_run != HD) width_bad++;
                hi_run = 0;
            end
            if (tck_o === 1'b1 && (tms_o !== prev_tms || tdi_o !== prev_tdi)) chg_hi_cnt++;
            if (tms_o === 1'b0) tms_zero_cnt++;
        end
        prev_tck = tck_o;
        prev_tms = tms_o;
        prev_tdi = tdi_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command, score latency/TDO/pulse count, optionally hold off the response.
    task automatic send_cmd(input string tag, input logic [5:0] len, input logic [31:0] tms,
                            input logic [31:0] tdi, input int hold);
        exp_t        e;
        logic [5:0]  clip;
        logic [32:0] m;
        int          n;
        int          waited;
        int          start_rise;
        clip     = (len > 6'd32) ? 6'd32 : len;
        m        = (33'd1 << clip) - 33'd1;
        e.tdo    = loop_en ? (tdi & m[31:0]) : (fix_tdo ? m[31:0] : 32'h0);
        e.lat    = 2 * int'(clip) * HD + 1;
        e.pulses = int'(clip);
        waited   = 0;
        @(negedge clk);
        while (cmd_ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1'b1;
        cmd_len_i   = len;
        cmd_tms_i   = tms;
        cmd_tdi_i   = tdi;
        start_rise  = rise_cnt;
        sb.push_back(e);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        n = 1;
        while (rsp_valid_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({tag, " rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        check({tag, " latency"}, 32'(n), 32'(e.lat));
        check({tag, " tdo"}, rsp_tdo_o, e.tdo);
        check({tag, " pulses"}, 32'(rise_cnt - start_rise), 32'(e.pulses));
        for (int i = 0; i < hold; i++) begin
            cmd_valid_i = 1'b1;
            @(negedge clk);
            check({tag, " hold tdo"}, rsp_tdo_o, e.tdo);
            check({tag, " hold valid"}, 32'(rsp_valid_o), 32'd1);
            check({tag, " hold ready"}, 32'(cmd_ready_o), 32'd0);
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check({tag, " post valid"}, 32'(rsp_valid_o), 32'd0);
        check({tag, " post ready"}, 32'(cmd_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int zero_start;
        int waited;
        rst         = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_len_i   = '0;
        cmd_tms_i   = '0;
        cmd_tdi_i   = '0;
        trst_req_i  = 1'b0;
        rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset rsp_tdo", rsp_tdo_o, 32'd0);
        check("reset tck", 32'(tck_o), 32'd0);
        check("reset tms", 32'(tms_o), 32'd1);
        check("reset tdi", 32'(tdi_o), 32'd0);
        check("reset trstn", 32'(trstn_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("release trstn", 32'(trstn_o), 32'd1);

        zero_start = tms_zero_cnt;
        send_cmd("len5 tms1f", 6'd5, 32'h1F, 32'h0, 0);
        check("len5 tms stays high", 32'(tms_zero_cnt - zero_start), 32'd0);

        loop_en = 1'b1;
        send_cmd("loop a5", 6'd8, 32'h0, 32'hA5, 0);
        send_cmd("len0", 6'd0, 32'h0, 32'hFFFF_FFFF, 0);
        send_cmd("len40 clip", 6'd40, 32'h0, 32'hFFFF_FFFF, 0);
        send_cmd("backpressure", 6'd3, 32'h2, 32'h5, 10);

        loop_en = 1'b0;
        fix_tdo = 1'b1;
        send_cmd("tdo1 len4", 6'd4, 32'h0, 32'h0, 0);
        fix_tdo = 1'b0;

        // Reset during the third HIGH phase of a 16-bit shift.
        loop_en = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (cmd_ready_o !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        cmd_valid_i = 1'b1;
        cmd_len_i   = 6'd16;
        cmd_tms_i   = 32'h0;
        cmd_tdi_i   = 32'hBEEF;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst pre tck", 32'(tck_o), 32'd1);
        check("midrst pre tms", 32'(tms_o), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst tck", 32'(tck_o), 32'd0);
        check("midrst tms", 32'(tms_o), 32'd1);
        check("midrst tdi", 32'(tdi_o), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst rsp_tdo", rsp_tdo_o, 32'd0);
        check("midrst cmd_ready", 32'(cmd_ready_o), 32'd0);
        rst = 1'b0;
        send_cmd("post rst len4", 6'd4, 32'h0, 32'h9, 0);

        // TAP reset request toggled while a shift is in flight.
        fork
            send_cmd("trst shift", 6'd6, 32'h0, 32'h2D, 0);
            begin
                repeat (6) @(negedge clk);
                check("trst before", 32'(trstn_o), 32'd1);
                trst_req_i = 1'b1;
                @(negedge clk);
                check("trst asserted", 32'(trstn_o), 32'd0);
                trst_req_i = 1'b0;
                @(negedge clk);
                check("trst released", 32'(trstn_o), 32'd1);
            end
        join

        check("bits changed while tck high", 32'(chg_hi_cnt), 32'd0);
        check("tck high width", 32'(width_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
